// File: rtl/alarm_bank.sv
// alarm_bank: NCH-channel push-button alarm with Idle/Armed/Alerting FSMs.
// Optional macro ALARM_AUTOCLEAR_EN: Alerting clears after ALERT_TIMEOUT cycles.
module alarm_bank #(
    parameter int NCH           = 4,
    parameter int CW            = 5,
    parameter int DEB_CYCLES    = 4,
    parameter int ALERT_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NCH-1:0]    btn_n,
    input  logic              arm_en,
    input  logic [CW-1:0]     delay,
    output logic [NCH-1:0]    press,
    output logic [2*NCH-1:0]  state,
    output logic [CW*NCH-1:0] count,
    output logic [NCH-1:0]    alert,
    output logic              any_alert
);

    typedef enum logic [1:0] {
        S_BAD   = 2'b00,
        S_IDLE  = 2'b01,
        S_ARMED = 2'b10,
        S_ALERT = 2'b11
    } st_t;

    localparam logic [15:0] DEB = 16'(DEB_CYCLES);

`ifdef ALARM_AUTOCLEAR_EN
    localparam int AW = (ALERT_TIMEOUT > 2) ? $clog2(ALERT_TIMEOUT) : 1;
    localparam logic [AW-1:0] ATO_LAST = AW'(ALERT_TIMEOUT - 1);
`endif

    logic [NCH-1:0] alert_d;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic          s1;
        logic          s2;
        logic [15:0]   rel;
        logic          pr;
        st_t           st_q;
        st_t           st_d;
        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;
        logic [CW-1:0] lim_q;
        logic [CW-1:0] lim_d;
`ifdef ALARM_AUTOCLEAR_EN
        logic [AW-1:0] ato_q;
        logic [AW-1:0] ato_d;
`endif

        // A press is accepted only after a full run of released cycles.
        assign pr = !s2 && (rel == DEB);

        // Synchronize the button and count released cycles up to DEB.
        always_ff @(posedge clk) begin
            if (reset) begin
                s1  <= 1'b1;
                s2  <= 1'b1;
                rel <= '0;
            end else begin
                s1 <= btn_n[i];
                s2 <= s1;
                if (pr)
                    rel <= '0;
                else if (s2 && rel != DEB)
                    rel <= rel + 16'd1;
            end
        end

        // Next state: cancel/acknowledge beat expiry; 00 recovers to Idle.
        always_comb begin
            st_d  = st_q;
            cnt_d = cnt_q;
            lim_d = lim_q;
`ifdef ALARM_AUTOCLEAR_EN
            ato_d = ato_q;
`endif
            case (st_q)
                S_IDLE: begin
                    if (pr && arm_en) begin
                        st_d  = S_ARMED;
                        cnt_d = '0;
                        lim_d = delay;
                    end
                end
                S_ARMED: begin
                    if (pr) begin
                        st_d = S_IDLE;
                    end else if (cnt_q == lim_q) begin
                        st_d = S_ALERT;
`ifdef ALARM_AUTOCLEAR_EN
                        ato_d = '0;
`endif
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_ALERT: begin
                    if (pr) begin
                        st_d  = S_IDLE;
                        cnt_d = '0;
`ifdef ALARM_AUTOCLEAR_EN
                    end else if (ato_q == ATO_LAST) begin
                        st_d  = S_IDLE;
                        cnt_d = '0;
                    end else begin
                        ato_d = ato_q + AW'(1);
`endif
                    end
                end
                default: st_d = S_IDLE;
            endcase
        end

        // Per-channel state, counter and latched delay limit.
        always_ff @(posedge clk) begin
            if (reset) begin
                st_q  <= S_IDLE;
                cnt_q <= '0;
                lim_q <= '0;
`ifdef ALARM_AUTOCLEAR_EN
                ato_q <= '0;
`endif
            end else begin
                st_q  <= st_d;
                cnt_q <= cnt_d;
                lim_q <= lim_d;
`ifdef ALARM_AUTOCLEAR_EN
                ato_q <= ato_d;
`endif
            end
        end

        assign alert_d[i]           = (st_d == S_ALERT);
        assign press[i]             = pr;
        assign state[2*i +: 2]      = st_q;
        assign count[CW*i +: CW]    = cnt_q;
    end

    // Alert flags are registered from the next state so they track state.
    always_ff @(posedge clk) begin
        if (reset) begin
            alert     <= '0;
            any_alert <= 1'b0;
        end else begin
            alert     <= alert_d;
            any_alert <= |alert_d;
        end
    end

endmodule

// File: doc/alarm_bank.md
# alarm_bank

Parametrised multi-channel alarm controller. Each of `NCH` channels takes an active-low push-button, conditions it with a synchronizer plus release-qualified press detector, and runs an Idle/Armed/Alerting state machine. The arming delay is loaded per arm event from a runtime input. The bank sits between the board push-buttons and the output pins, replacing the fixed single-channel, fixed-delay alarm.

## Interface
- `NCH`, 4: number of independent channels (1..8).
- `CW`, 5: delay counter width in bits.
- `DEB_CYCLES`, 4: consecutive released cycles required before a press is accepted (1..2^16-1).
- `ALERT_TIMEOUT`, 255: cycles in Alerting before auto-clear; used only with `ALARM_AUTOCLEAR_EN`.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `btn_n`  in  NCH  raw asynchronous buttons, active-low (0 = pressed).
- `arm_en`  in  1  global arm permit; when 0, presses in Idle are ignored.
- `delay`  in  CW  arming delay, sampled at the arm event.
- `press`  out  NCH  one-cycle qualified press pulse per channel.
- `state`  out  2*NCH  per-channel state; channel i at bits [2i+1:2i].
- `count`  out  CW*NCH  per-channel delay counter; channel i at bits [CW*i+CW-1:CW*i].
- `alert`  out  NCH  1 while the channel is in Alerting.
- `any_alert`  out  1  OR of `alert`.

## Operation
- State encoding: Idle = 2'b01, Armed = 2'b10, Alerting = 2'b11. 2'b00 is illegal and recovers to Idle on the next edge.
- Conditioning, per channel:
  - 2-FF synchronizer. Both stages reset to 1.
  - `rel` counter, 16 bits, reset 0. It increments, saturating at `DEB_CYCLES`, while the synced input is 1.
  - `press[i]` = synced input is 0 AND `rel == DEB_CYCLES`. The press cycle clears `rel` to 0.
  - A held button therefore yields exactly one pulse. Chatter shorter than `DEB_CYCLES` released cycles yields no new pulse.
- FSM, per channel. Transitions occur on the edge that ends the cycle in which the condition holds.
  - Idle, `press & arm_en`: go to Armed, `count <= 0`, `lim <= delay`.
  - Armed, `press`: cancel to Idle. This has priority over expiry.
  - Armed, `count == lim`: go to Alerting; `count` holds.
  - Armed, otherwise: `count <= count + 1`. No wrap is possible because `count` never passes `lim`.
  - Alerting, `press`: acknowledge to Idle, `count <= 0`.
- `arm_en` affects only the Idle->Armed transition; cancel and acknowledge always work.
- Channels are fully independent. Simultaneous presses on several channels are each processed in the same cycle.

## Timing
- Reset values:
  - `state` = all Idle (01).
  - `count` = 0, `lim` = 0.
  - `press`, `alert`, `any_alert` = 0.
  - Synchronizers = 1, `rel` = 0. A button must be seen released for `DEB_CYCLES` cycles after reset before any press is accepted.
- Reset asserted mid-operation forces the reset values on the next edge, regardless of state or input.
- Latency from `btn_n` fall (sampled at edge E) to `press`: `press` is high in the cycle after edge E+1, provided `rel` is saturated.
- The state changes at the edge ending the `press` cycle.
- Armed dwell time: exactly `lim + 1` cycles. `delay = 0` gives Alerting after 1 Armed cycle; `delay = 2^CW - 1` gives 2^CW cycles.
- `alert` and `any_alert` are registered, decoded from `state`, and change in the same cycle as `state`.
- A press coinciding with `count == lim` in Armed: the channel goes to Idle, not Alerting.

## Configuration
- `ALARM_AUTOCLEAR_EN` defined:
  - Each channel has an `ato` timeout counter (width fits `ALERT_TIMEOUT`), cleared on entry to Alerting and incremented each Alerting cycle.
  - When `ato == ALERT_TIMEOUT - 1`, the channel returns to Idle at that edge, so Alerting lasts exactly `ALERT_TIMEOUT` cycles.
  - A press in the same cycle also goes to Idle (same result).
- Not defined: no timeout counter is built, `ALERT_TIMEOUT` is ignored, and Alerting persists until a press or reset.

## Test plan
- Reset, hold `btn_n` = all 1 for 10 cycles, pulse `btn_n[0]` low for 6 cycles, `delay` = 3, `arm_en` = 1 -> exactly one `press[0]` pulse; state0 01->10; `count` 0,1,2,3; Alerting after 4 Armed cycles; `alert` = 0001; `any_alert` = 1.
- `btn_n[1]` pressed with no prior release (immediately after reset) -> no `press[1]`. After 4 released cycles, next press arms channel 1.
- Armed with `delay` = 5; press when `count` = 5 -> state returns to 01 with no `alert` pulse. Separately, press at `count` = 2 -> cancel to Idle.
- `arm_en` = 0, press channel 2 in Idle -> stays 01. Then with channel 3 in Alerting, `arm_en` = 0, press -> acknowledge to 01 and `count` = 0.
- All 4 channels pressed in the same cycle with `delay` = 0 -> all Armed together, all Alerting one cycle later; assert `reset` for 1 cycle mid-Alerting -> all outputs return to reset values.
- With `ALARM_AUTOCLEAR_EN` and `ALERT_TIMEOUT` = 8 -> `alert` high exactly 8 cycles, then Idle. Without the macro -> `alert` still high after 300 cycles.
